// File: rtl/clk_sched_pkg.sv
// rtl/clk_sched_pkg.sv - shared types and constants for the clock-waveform scheduler
// Contents: state_t (IDLE/DELAY/RUN/STOPPING), cfg_t {div, high, phase}, CFG_W, MIN_DIV.
package clk_sched_pkg;

    localparam int CFG_W = 16;

    // Smallest period that still has both a high and a low cycle.
    localparam logic [CFG_W-1:0] MIN_DIV = CFG_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RUN,
        STOPPING
    } state_t;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] phase;
    } cfg_t;

endpackage

// File: rtl/clk_div_sched_if.sv
// rtl/clk_div_sched_if.sv - configuration handshake bundle for the clock scheduler
// Signals: cfg_valid/cfg_ready handshake, cfg_div/cfg_high/cfg_phase request, cfg_err clamp pulse.
// master drives the request, slave (the scheduler) answers with ready and err.
interface clk_div_sched_if
    import clk_sched_pkg::*;
#(
    parameter int CNT_W = CFG_W
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_phase;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_div, cfg_high, cfg_phase,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_high, cfg_phase,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clk_cfg_clamp.sv
// rtl/clk_cfg_clamp.sv - combinational legalisation of a requested clock configuration
// Ports: div_i/high_i/phase_i requested values; cfg_o legal config; err_o set if any field was clamped.
module clk_cfg_clamp
    import clk_sched_pkg::*;
(
    input  logic [CFG_W-1:0] div_i,
    input  logic [CFG_W-1:0] high_i,
    input  logic [CFG_W-1:0] phase_i,
    output cfg_t             cfg_o,
    output logic             err_o
);
    logic [CFG_W-1:0] div_c;
    logic [CFG_W-1:0] high_nz;
    logic             div_low;
    logic             high_zero;
    logic             high_wide;

    always_comb begin
        div_low   = div_i < MIN_DIV;
        div_c     = div_low ? MIN_DIV : div_i;
        high_zero = high_i == '0;
        high_nz   = high_zero ? CFG_W'(1) : high_i;
        // High time is checked against the already-clamped period so the
        // result always leaves at least one low cycle.
        high_wide = high_nz >= div_c;

        cfg_o.div   = div_c;
        cfg_o.high  = high_wide ? (div_c - CFG_W'(1)) : high_nz;
        cfg_o.phase = phase_i;
        err_o       = div_low || high_zero || high_wide;
    end
endmodule

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - programmable divided-clock generator with glitch-free start/stop
// Ports: clk, rst (sync, active high), enable level request, cfg (slave handshake bundle),
//        clk_out registered divided clock, running (not IDLE), period_tick (last cycle of period).
module clk_div_sched
    import clk_sched_pkg::*;
#(
    parameter int CNT_W     = CFG_W,
    parameter int DEF_DIV   = 4,
    parameter int DEF_HIGH  = 2,
    parameter int DEF_PHASE = 0
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    clk_div_sched_if.slave  cfg,
    output logic            clk_out,
    output logic            running,
    output logic            period_tick
);
    localparam cfg_t DEF_CFG = '{
        div:   CFG_W'(DEF_DIV),
        high:  CFG_W'(DEF_HIGH),
        phase: CFG_W'(DEF_PHASE)
    };

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cfg_t             act_q, act_d;
    cfg_t             pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             cfg_err_q, cfg_err_d;

    cfg_t             clamped;
    logic             clamp_err;
    logic             accept;
    logic             last_cnt;
    logic             in_period;
    logic             apply;

    clk_cfg_clamp u_clamp (
        .div_i   (cfg.cfg_div),
        .high_i  (cfg.cfg_high),
        .phase_i (cfg.cfg_phase),
        .cfg_o   (clamped),
        .err_o   (clamp_err)
    );

    assign cfg.cfg_ready = !pend_vld_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign clk_out       = clk_out_q;
    assign running       = state_q != IDLE;
    assign period_tick   = in_period && last_cnt;

    always_comb begin
        accept    = cfg.cfg_valid && !pend_vld_q;
        last_cnt  = cnt_q == (act_q.div - CFG_W'(1));
        in_period = (state_q == RUN) || (state_q == STOPPING);
        // Pending config lands either straight away when idle or exactly on a
        // period boundary, so a running waveform never sees a partial period.
        apply     = pend_vld_q && ((state_q == IDLE) || (in_period && last_cnt));

        act_d      = apply ? pend_q : act_q;
        pend_d     = accept ? clamped : pend_q;
        pend_vld_d = pend_vld_q;
        if (apply) begin
            pend_vld_d = 1'b0;
        end
        if (accept) begin
            pend_vld_d = 1'b1;
        end
        cfg_err_d = accept && clamp_err;

        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = (act_d.phase == '0) ? RUN : DELAY;
                end
            end
            DELAY: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == (act_q.phase - CFG_W'(1))) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (last_cnt) begin
                    cnt_d = '0;
                    // Dropping enable on the final cycle ends cleanly here;
                    // entering STOPPING would start a fresh period.
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!enable) begin
                        state_d = STOPPING;
                    end
                end
            end
            STOPPING: begin
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = enable ? RUN : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (enable) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        clk_out_d = ((state_d == RUN) || (state_d == STOPPING)) && (cnt_d < act_d.high);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            act_q      <= DEF_CFG;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            cfg_err_q  <= cfg_err_d;
        end
    end
endmodule

// File: tb/tb_clk_div_sched.sv
// tb/tb_clk_div_sched.sv - scoreboard bench for clk_div_sched
module tb_clk_div_sched;
    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic clk_out;
    logic running;
    logic period_tick;

    clk_div_sched_if #(.CNT_W(16)) cfg_if ();

    clk_div_sched dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg         (cfg_if),
        .clk_out     (clk_out),
        .running     (running),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Expected event cycles: 0 rise of clk_out, 1 fall, 2 period_tick, 3 cfg_err.
    int    exp_rise[$];
    int    exp_fall[$];
    int    exp_tick[$];
    int    exp_err[$];
    string kname[4] = '{"rise", "fall", "tick", "err"};

    bit   mon_en = 1'b0;
    logic prev_clk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d required %0d", name, cyc, act, exp_v);
        end
    endtask

    task automatic sb_event(input int kind);
        int exp_c;
        bit have;
        have  = 1'b0;
        exp_c = 0;
        case (kind)
            0: if (exp_rise.size() > 0) begin exp_c = exp_rise.pop_front(); have = 1'b1; end
            1: if (exp_fall.size() > 0) begin exp_c = exp_fall.pop_front(); have = 1'b1; end
            2: if (exp_tick.size() > 0) begin exp_c = exp_tick.pop_front(); have = 1'b1; end
            default: if (exp_err.size() > 0) begin exp_c = exp_err.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL sb_%s: event at cycle %0d, none required", kname[kind], cyc);
        end else if (exp_c != cyc) begin
            errors++;
            $display("FAIL sb_%s: event at cycle %0d, required cycle %0d", kname[kind], cyc, exp_c);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (clk_out === 1'b1 && prev_clk === 1'b0) sb_event(0);
            if (clk_out === 1'b0 && prev_clk === 1'b1) sb_event(1);
            if (period_tick === 1'b1) sb_event(2);
            if (cfg_if.cfg_err === 1'b1) sb_event(3);
        end
        prev_clk = clk_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic send_cfg(input int dv, input int hi, input int ph);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 16'(dv);
        cfg_if.cfg_high  = 16'(hi);
        cfg_if.cfg_phase = 16'(ph);
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_clk_out"}, 32'(clk_out), 0);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_period_tick"}, 32'(period_tick), 0);
        chk({tag, "_cfg_err"}, 32'(cfg_if.cfg_err), 0);
        chk({tag, "_cfg_ready"}, 32'(cfg_if.cfg_ready), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    int t, s, p, e, m, c, d, r;

    initial begin
        rst              = 1'b1;
        enable           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_high  = '0;
        cfg_if.cfg_phase = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs("reset");
        mon_en = 1'b1;

        // Default 4/2/0 waveform, stop dropped at cnt=0 of the third period.
        t = cyc;
        exp_rise.push_back(t + 1); exp_rise.push_back(t + 5); exp_rise.push_back(t + 9);
        exp_fall.push_back(t + 3); exp_fall.push_back(t + 7); exp_fall.push_back(t + 11);
        exp_tick.push_back(t + 4); exp_tick.push_back(t + 8); exp_tick.push_back(t + 12);
        enable = 1'b1;
        go_to(t + 9);
        enable = 1'b0;
        go_to(t + 12);
        chk("stop_running_last", 32'(running), 1);
        go_to(t + 13);
        chk("stop_running_idle", 32'(running), 0);
        chk("stop_clk_low", 32'(clk_out), 0);
        go_to(t + 16);

        // Stop then resume inside STOPPING: waveform continues unchanged.
        s = cyc;
        exp_rise.push_back(s + 1); exp_rise.push_back(s + 5); exp_rise.push_back(s + 9);
        exp_fall.push_back(s + 3); exp_fall.push_back(s + 7); exp_fall.push_back(s + 11);
        exp_tick.push_back(s + 4); exp_tick.push_back(s + 8); exp_tick.push_back(s + 12);
        enable = 1'b1;
        go_to(s + 5);
        enable = 1'b0;
        go_to(s + 6);
        chk("resume_running", 32'(running), 1);
        enable = 1'b1;
        go_to(s + 12);
        enable = 1'b0;
        go_to(s + 13);
        chk("resume_idle", 32'(running), 0);
        go_to(s + 15);

        // Phase delay: 5/2/3 loaded in IDLE.
        p = cyc;
        send_cfg(5, 2, 3);
        chk("idle_cfg_ready_low", 32'(cfg_if.cfg_ready), 0);
        tick();
        chk("idle_cfg_ready_back", 32'(cfg_if.cfg_ready), 1);
        tick();
        e = cyc;
        exp_rise.push_back(e + 4); exp_rise.push_back(e + 9);
        exp_fall.push_back(e + 6); exp_fall.push_back(e + 11);
        exp_tick.push_back(e + 8); exp_tick.push_back(e + 13);
        chk("phase_running_before", 32'(running), 0);
        enable = 1'b1;
        tick();
        chk("phase_running_delay", 32'(running), 1);
        go_to(e + 13);
        enable = 1'b0;
        go_to(e + 14);
        chk("phase_idle", 32'(running), 0);
        go_to(e + 16);

        // Mid-run reconfig 4/2 -> 6/3 sent at cnt=1.
        send_cfg(4, 2, 0);
        tick();
        tick();
        m = cyc;
        exp_rise.push_back(m + 1); exp_rise.push_back(m + 5); exp_rise.push_back(m + 9); exp_rise.push_back(m + 15);
        exp_fall.push_back(m + 3); exp_fall.push_back(m + 7); exp_fall.push_back(m + 12); exp_fall.push_back(m + 18);
        exp_tick.push_back(m + 4); exp_tick.push_back(m + 8); exp_tick.push_back(m + 14); exp_tick.push_back(m + 20);
        enable = 1'b1;
        go_to(m + 6);
        chk("reconf_ready_before", 32'(cfg_if.cfg_ready), 1);
        send_cfg(6, 3, 0);
        chk("reconf_ready_low_a", 32'(cfg_if.cfg_ready), 0);
        tick();
        chk("reconf_ready_low_b", 32'(cfg_if.cfg_ready), 0);
        tick();
        chk("reconf_ready_boundary", 32'(cfg_if.cfg_ready), 1);
        go_to(m + 20);
        enable = 1'b0;
        go_to(m + 21);
        chk("reconf_idle", 32'(running), 0);
        go_to(m + 23);

        // Clamp: 1/0 -> 2/1, then 3/7 -> 3/2.
        c = cyc;
        exp_err.push_back(c + 1);
        send_cfg(1, 0, 0);
        go_to(c + 3);
        exp_rise.push_back(c + 4); exp_rise.push_back(c + 6);
        exp_fall.push_back(c + 5); exp_fall.push_back(c + 7);
        exp_tick.push_back(c + 5); exp_tick.push_back(c + 7);
        enable = 1'b1;
        go_to(c + 7);
        enable = 1'b0;
        go_to(c + 8);
        chk("clamp1_idle", 32'(running), 0);
        go_to(c + 9);
        exp_err.push_back(c + 10);
        send_cfg(3, 7, 0);
        go_to(c + 12);
        exp_rise.push_back(c + 13); exp_rise.push_back(c + 16);
        exp_fall.push_back(c + 15); exp_fall.push_back(c + 18);
        exp_tick.push_back(c + 15); exp_tick.push_back(c + 18);
        enable = 1'b1;
        go_to(c + 18);
        enable = 1'b0;
        go_to(c + 19);
        chk("clamp2_idle", 32'(running), 0);
        go_to(c + 21);

        // Abort during an 8-cycle DELAY at delay count 4: no edge at all.
        send_cfg(4, 2, 8);
        tick();
        tick();
        d = cyc;
        enable = 1'b1;
        tick();
        chk("abort_running_delay", 32'(running), 1);
        go_to(d + 5);
        enable = 1'b0;
        chk("abort_running_cnt4", 32'(running), 1);
        go_to(d + 6);
        chk("abort_idle", 32'(running), 0);
        chk("abort_clk_low", 32'(clk_out), 0);
        go_to(d + 12);

        // Reset in RUN with a config pending: defaults return, pending dropped.
        send_cfg(6, 3, 0);
        tick();
        tick();
        r = cyc;
        exp_rise.push_back(r + 1); exp_rise.push_back(r + 7); exp_rise.push_back(r + 11); exp_rise.push_back(r + 15);
        exp_fall.push_back(r + 4); exp_fall.push_back(r + 9); exp_fall.push_back(r + 13); exp_fall.push_back(r + 17);
        exp_tick.push_back(r + 6); exp_tick.push_back(r + 14); exp_tick.push_back(r + 18);
        enable = 1'b1;
        go_to(r + 7);
        send_cfg(8, 4, 0);
        chk("rst_pending_ready", 32'(cfg_if.cfg_ready), 0);
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        chk("midrst_ready_after", 32'(cfg_if.cfg_ready), 1);
        enable = 1'b1;
        go_to(r + 18);
        enable = 1'b0;
        go_to(r + 19);
        chk("midrst_idle", 32'(running), 0);
        go_to(r + 22);

        chk("sb_rise_left", 32'(exp_rise.size()), 0);
        chk("sb_fall_left", 32'(exp_fall.size()), 0);
        chk("sb_tick_left", 32'(exp_tick.size()), 0);
        chk("sb_err_left", 32'(exp_err.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
